icache_refill_ctrl: RTL and testbench

// Miss handler for the dual-port instruction cache. Takes per-lane miss flags and fetch

---
 rtl/icache_refill_ctrl_pkg.sv | 23 ++
 rtl/icache_refill_ctrl.sv | 101 ++++++++++
 tb/tb_icache_refill_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared refill-controller definitions: line geometry, derived field widths and FSM encoding.
package icache_refill_ctrl_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned INDEX_BITS = 6;
  localparam int unsigned OFF_BITS   = $clog2(LINE_WORDS);
  localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - OFF_BITS - 2;
  localparam int unsigned LINE_LSB   = OFF_BITS + 2;
  localparam int unsigned TAG_LSB    = INDEX_BITS + OFF_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Clear the word-offset and byte-offset bits of a fetch address.
  function automatic logic [31:0] line_align(input logic [31:0] a);
    return a & ~((32'd1 << LINE_LSB) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: serialises lane misses, fetches one line per miss,
// writes the data words first and the tag last so a partial line is never valid.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss1,
  input  logic                  miss2,
  input  logic [31:0]           addr1,
  input  logic [31:0]           addr2,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  fill_we,
  output logic [INDEX_BITS-1:0] fill_index,
  output logic [OFF_BITS-1:0]   fill_word,
  output logic [31:0]           fill_data,
  output logic                  tag_we,
  output logic [TAG_BITS-1:0]   tag_data,
  output logic                  stall,
  output logic                  busy
);

  state_e              state_q, state_d;
  logic [OFF_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic                mem_req_q, mem_req_d;

  // State, word counter, latched line address and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      mem_req_q <= mem_req_d;
    end
  end

  // Next-state and strobe logic; lane 1 wins when both lanes miss (older instruction).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mem_req_d = mem_req_q;
    fill_we   = 1'b0;
    tag_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (miss1) begin
          addr_d    = line_align(addr1);
          mem_req_d = 1'b1;
          state_d   = ST_REQ;
        end else if (miss2) begin
          addr_d    = line_align(addr2);
          mem_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mem_rvalid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + OFF_BITS'(1);
          if (cnt_q == OFF_BITS'(LINE_WORDS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        tag_we  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address-derived outputs come straight from the latched line register.
  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign fill_index = addr_q[TAG_LSB-1:LINE_LSB];
  assign tag_data   = addr_q[31:TAG_LSB];
  assign fill_word  = cnt_q;
  assign fill_data  = fill_we ? mem_rdata : 32'd0;
  assign busy       = (state_q != ST_IDLE);
  assign stall      = miss1 | miss2 | busy;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for the instruction-cache refill controller.
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  miss1, miss2;
  logic [31:0]           addr1, addr2;
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic                  fill_we;
  logic [INDEX_BITS-1:0] fill_index;
  logic [OFF_BITS-1:0]   fill_word;
  logic [31:0]           fill_data;
  logic                  tag_we;
  logic [TAG_BITS-1:0]   tag_data;
  logic                  stall;
  logic                  busy;

  int checks = 0;
  int passed = 0;
  int tag_cnt = 0;
  int tc0;

  icache_refill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .miss1      (miss1),
    .miss2      (miss2),
    .addr1      (addr1),
    .addr2      (addr2),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fill_we    (fill_we),
    .fill_index (fill_index),
    .fill_word  (fill_word),
    .fill_data  (fill_data),
    .tag_we     (tag_we),
    .tag_data   (tag_data),
    .stall      (stall),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count tag-write pulses seen at clock edges.
  always @(posedge clk) begin
    if (tag_we === 1'b1) tag_cnt <= tag_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Drive one line from REQ (just entered) through DONE; leaves the bench in the DONE cycle.
  task automatic fill_line(input logic [31:0] exp_addr, input logic [31:0] exp_idx,
                           input logic [31:0] exp_tag, input int gnt_dly, input bit noise,
                           input logic [15:0] pat, input int npat, input int drop_at,
                           input logic [31:0] dbase);
    int w;
    for (int i = 0; i < gnt_dly; i++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = noise;
      mem_rdata  = 32'hBAD0_0000 | 32'(i);
      #1;
      chk1("req_hold", mem_req, 1'b1);
      chk("req_addr", mem_addr, exp_addr);
      if (noise) chk1("req_rvalid_ignored", fill_we, 1'b0);
      tick();
    end
    mem_gnt    = 1'b1;
    mem_rvalid = noise;
    mem_rdata  = 32'hBAD1_0000;
    #1;
    chk1("gnt_cycle_req", mem_req, 1'b1);
    chk("gnt_cycle_addr", mem_addr, exp_addr);
    chk1("gnt_cycle_no_fill", fill_we, 1'b0);
    tick();
    mem_gnt = 1'b0;
    chk1("req_cleared", mem_req, 1'b0);
    w = 0;
    for (int i = 0; i < npat; i++) begin
      if (i == drop_at) begin
        miss1 = 1'b0;
        miss2 = 1'b0;
      end
      mem_rvalid = pat[i];
      mem_rdata  = pat[i] ? (dbase + 32'(w)) : 32'hDEAD_BEEF;
      #1;
      chk1("fill_busy", busy, 1'b1);
      if (pat[i]) begin
        chk1("fill_we", fill_we, 1'b1);
        chk("fill_word", 32'(fill_word), 32'(w));
        chk("fill_data", fill_data, dbase + 32'(w));
        chk("fill_index", 32'(fill_index), exp_idx);
        w++;
      end else begin
        chk1("gap_no_fill", fill_we, 1'b0);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    chk1("done_tag_we", tag_we, 1'b1);
    chk("done_tag_data", 32'(tag_data), exp_tag);
    chk("done_index", 32'(fill_index), exp_idx);
    chk1("done_no_fill", fill_we, 1'b0);
  endtask

  initial begin
    rst = 1'b1; miss1 = 1'b0; miss2 = 1'b0; addr1 = '0; addr2 = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) tick();

    // Reset state: every output zero.
    chk1("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk1("rst_fill_we", fill_we, 1'b0);
    chk("rst_fill_word", 32'(fill_word), 32'd0);
    chk("rst_fill_data", fill_data, 32'd0);
    chk("rst_fill_index", 32'(fill_index), 32'd0);
    chk1("rst_tag_we", tag_we, 1'b0);
    chk("rst_tag_data", 32'(tag_data), 32'd0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // gnt/rvalid in IDLE are ignored.
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk1("idle_rvalid_no_fill", fill_we, 1'b0);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk1("idle_gnt_stays_idle", busy, 1'b0);

    // Test 1: single lane-1 miss at 0x140, gnt after 2 clk, back-to-back data.
    miss1 = 1'b1; addr1 = 32'h0000_0140;
    #1;
    chk1("t1_stall_comb", stall, 1'b1);
    chk1("t1_req_not_yet", mem_req, 1'b0);
    tick();
    chk1("t1_req_latency", mem_req, 1'b1);
    chk1("t1_busy", busy, 1'b1);
    fill_line(32'h0000_0140, 32'h14, 32'h0, 2, 1'b0, 16'h000F, 4, -1, 32'hA000_0000);
    miss1 = 1'b0;
    tick();
    chk1("t1_tag_we_one", tag_we, 1'b0);
    chk1("t1_stall_low", stall, 1'b0);
    chk1("t1_busy_low", busy, 1'b0);
    chk("t1_tag_count", 32'(tag_cnt), 32'd1);

    // Test 2: both lanes miss different lines; lane 1 first, lane 2 follows.
    miss1 = 1'b1; addr1 = 32'h0000_0100;
    miss2 = 1'b1; addr2 = 32'h0000_2040;
    tick();
    chk("t2_first_addr", mem_addr, 32'h0000_0100);
    fill_line(32'h0000_0100, 32'h10, 32'h0, 0, 1'b0, 16'h000F, 4, -1, 32'hB000_0000);
    miss1 = 1'b0;
    tick();
    chk1("t2_idle_busy", busy, 1'b0);
    chk1("t2_idle_stall", stall, 1'b1);
    chk1("t2_idle_no_req", mem_req, 1'b0);
    tick();
    chk1("t2_second_req", mem_req, 1'b1);
    chk("t2_second_addr", mem_addr, 32'h0000_2040);
    fill_line(32'h0000_2040, 32'h04, 32'h8, 0, 1'b0, 16'h000F, 4, -1, 32'hC000_0000);
    miss2 = 1'b0;
    tick();
    chk1("t2_stall_low", stall, 1'b0);
    chk("t2_tag_count", 32'(tag_cnt), 32'd3);

    // Test 3: both lanes miss the same line; one refill serves both.
    tc0 = tag_cnt;
    miss1 = 1'b1; addr1 = 32'h0000_0104;
    miss2 = 1'b1; addr2 = 32'h0000_0108;
    tick();
    chk("t3_addr", mem_addr, 32'h0000_0100);
    fill_line(32'h0000_0100, 32'h10, 32'h0, 1, 1'b0, 16'h000F, 4, -1, 32'hD000_0000);
    miss1 = 1'b0; miss2 = 1'b0;
    tick();
    chk1("t3_stall_low", stall, 1'b0);
    tick();
    chk1("t3_no_second_req", mem_req, 1'b0);
    chk1("t3_no_second_busy", busy, 1'b0);
    chk("t3_one_tag", 32'(tag_cnt - tc0), 32'd1);

    // Test 4: lane-2 only miss, unaligned address, rvalid with gaps 1,0,0,1,1,0,1.
    miss2 = 1'b1; addr2 = 32'hABCD_E7F8;
    tick();
    chk("t4_aligned_addr", mem_addr, 32'hABCD_E7F0);
    fill_line(32'hABCD_E7F0, 32'h3F, 32'h2AF379, 0, 1'b0, 16'h0059, 7, -1, 32'hE000_0000);
    miss2 = 1'b0;
    tick();
    chk1("t4_idle", busy, 1'b0);

    // Test 5: rvalid noise in REQ and gnt cycle; miss1 drops mid-FILL, line still completes.
    tc0 = tag_cnt;
    miss1 = 1'b1; addr1 = 32'h0000_0440;
    tick();
    fill_line(32'h0000_0440, 32'h04, 32'h1, 2, 1'b1, 16'h000F, 4, 2, 32'hF000_0000);
    tick();
    chk1("t5_idle", busy, 1'b0);
    chk("t5_tag_written", 32'(tag_cnt - tc0), 32'd1);

    // Test 6: reset after 2 of 4 words; no tag write ever follows.
    tc0 = tag_cnt;
    miss1 = 1'b1; addr1 = 32'h0000_0300;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h5500_0000 + 32'(i);
      #1;
      chk1("t6_partial_fill", fill_we, 1'b1);
      tick();
    end
    rst = 1'b1; miss1 = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5500_0002;
    tick();
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_req", mem_req, 1'b0);
    chk1("t6_rst_fill_we", fill_we, 1'b0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    rst = 1'b0; mem_rvalid = 1'b0;
    repeat (4) tick();
    chk1("t6_stay_idle", busy, 1'b0);
    chk("t6_no_tag", 32'(tag_cnt - tc0), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
